// File: rtl/mem_result_checker_pkg.sv
// Shared geometry and FSM encodings for the result-memory read-back checker.
// Top_controller memories use the same geometry constants.
package mem_result_checker_pkg;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 22;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_result_checker_res_cmp_stage.sv
// Compare stage: bitwise result/golden comparison one cycle behind issue,
// accumulating the mismatch count and the lowest failing address.
module res_cmp_stage
    import mem_result_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_res_rdata,
    input  logic [DATA_W-1:0] i_gold_rdata,
    output logic              o_mismatch,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_first_err_vld
);

    logic w_mismatch;

    always_comb begin
        w_mismatch = i_vld && (i_res_rdata != i_gold_rdata);
    end

    assign o_mismatch = w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_first_err_vld  <= 1'b0;
        end else if (i_clr) begin
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_first_err_vld  <= 1'b0;
        end else if (w_mismatch) begin
            // Count is one bit wider than the address, so DEPTH mismatches never wrap.
            o_err_cnt <= o_err_cnt + 1'b1;
            if (!o_first_err_vld) begin
                o_first_err_addr <= i_addr;
                o_first_err_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_result_checker.sv
// Hardware read-back checker: sweeps the result and golden memories in lockstep
// and reports mismatch count, first failing address and a pass flag.
module mem_result_checker
    import mem_result_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              res_en,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [DATA_W-1:0] res_rdata,
    output logic              gold_en,
    output logic [ADDR_W-1:0] gold_addr,
    input  logic [DATA_W-1:0] gold_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_vld
);

    state_t            r_state;
    logic              r_cmp_vld;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              w_clr;
    logic              w_mismatch;

    assign gold_en   = res_en;
    assign gold_addr = res_addr;
    assign w_clr     = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            res_en     <= 1'b0;
            res_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
        end else begin
            r_cmp_vld  <= res_en;
            r_cmp_addr <= res_addr;
            done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_READ;
                        res_en   <= 1'b1;
                        res_addr <= '0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (res_addr == LAST_ADDR) begin
                        r_state <= ST_DRAIN;
                        res_en  <= 1'b0;
                    end else begin
                        res_addr <= res_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The final compare registers on this same edge, so fold its strobe in.
                    r_state <= ST_DONE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= (err_cnt == '0) && !w_mismatch;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    res_cmp_stage u_cmp (
        .clk              (clk),
        .rst              (rst),
        .i_clr            (w_clr),
        .i_vld            (r_cmp_vld),
        .i_addr           (r_cmp_addr),
        .i_res_rdata      (res_rdata),
        .i_gold_rdata     (gold_rdata),
        .o_mismatch       (w_mismatch),
        .o_err_cnt        (err_cnt),
        .o_first_err_addr (first_err_addr),
        .o_first_err_vld  (first_err_vld)
    );

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed testbench for mem_result_checker with behavioural result/golden memories.
module tb_mem_result_checker;
    import mem_result_checker_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              res_en, gold_en, busy, done, pass, first_err_vld;
    logic [ADDR_W-1:0] res_addr, gold_addr, first_err_addr;
    logic [DATA_W-1:0] res_rdata, gold_rdata;
    logic [ADDR_W:0]   err_cnt;

    logic [DATA_W-1:0] res_mem  [DEPTH];
    logic [DATA_W-1:0] gold_mem [DEPTH];

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned       rd_cnt = 0;
    int unsigned       seq_err = 0;
    int unsigned       lock_err = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;
    logic [ADDR_W-1:0] exp_addr = '0;

    always #5 clk = ~clk;

    mem_result_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .res_en         (res_en),
        .res_addr       (res_addr),
        .res_rdata      (res_rdata),
        .gold_en        (gold_en),
        .gold_addr      (gold_addr),
        .gold_rdata     (gold_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_vld  (first_err_vld)
    );

    always @(posedge clk) begin
        if (res_en) res_rdata <= res_mem[res_addr];
        if (gold_en) gold_rdata <= gold_mem[gold_addr];
    end

    // Read monitor: counts issued reads, checks in-order addressing and gold/res lockstep.
    always @(posedge clk) begin
        if (res_en) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= res_addr;
            if (res_addr != exp_addr) seq_err <= seq_err + 1;
        end
        exp_addr <= res_en ? res_addr + 1'b1 : '0;
        if (gold_en != res_en || gold_addr != res_addr) lock_err <= lock_err + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem(input int unsigned mode);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            gold_mem[i] = DATA_W'($urandom);
            res_mem[i]  = (mode == 3) ? ~gold_mem[i] : gold_mem[i];
        end
        if (mode == 1) res_mem[12'h7FF] = res_mem[12'h7FF] ^ 22'h000001;
        if (mode == 2) begin
            res_mem[0]      = res_mem[0] ^ 22'h200000;
            res_mem[DEPTH-1] = res_mem[DEPTH-1] ^ 22'h000400;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, ".res_en"},   32'(res_en), 0);
        check_val({name, ".gold_en"},  32'(gold_en), 0);
        check_val({name, ".res_addr"}, 32'(res_addr), 0);
        check_val({name, ".gold_addr"}, 32'(gold_addr), 0);
        check_val({name, ".busy"},     32'(busy), 0);
        check_val({name, ".done"},     32'(done), 0);
        check_val({name, ".pass"},     32'(pass), 0);
        check_val({name, ".err_cnt"},  32'(err_cnt), 0);
        check_val({name, ".ferr_addr"}, 32'(first_err_addr), 0);
        check_val({name, ".ferr_vld"}, 32'(first_err_vld), 0);
    endtask

    // extra_start: cycle index (after E0) whose edge sees a second start; abort_at: assert rst there.
    task automatic run_check(input string name, input int unsigned extra_start,
                             input int unsigned abort_at);
        int unsigned n;
        int unsigned rd0;
        int unsigned seq0;
        int unsigned lock0;
        int unsigned dones;
        bit          got_done;
        @(negedge clk);
        rd0 = rd_cnt; seq0 = seq_err; lock0 = lock_err;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({name, ".busy_E0"}, 32'(busy), 1);
        check_val({name, ".pass_clr"}, 32'(pass), 0);
        check_val({name, ".errcnt_clr"}, 32'(err_cnt), 0);
        n = 0;
        got_done = 0;
        while (n < DEPTH + 20 && !got_done) begin
            @(posedge clk);
            n++;
            #1;
            start = (extra_start != 0 && n == extra_start - 1);
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({name, ".abort"});
                dones = 0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    if (done) dones++;
                end
                check_val({name, ".no_done"}, dones, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) got_done = 1;
        end
        check_val({name, ".latency"}, n, DEPTH + 1);
        check_val({name, ".busy_at_done"}, 32'(busy), 0);
        check_val({name, ".reads"}, rd_cnt - rd0, DEPTH);
        check_val({name, ".last_addr"}, 32'(last_rd_addr), DEPTH - 1);
        check_val({name, ".addr_order"}, seq_err - seq0, 0);
        check_val({name, ".lockstep"}, lock_err - lock0, 0);
        @(posedge clk);
        #1;
        check_val({name, ".done_pulse"}, 32'(done), 0);
    endtask

    task automatic check_results(input string name, input int unsigned e_cnt,
                                 input int unsigned e_addr, input bit e_vld, input bit e_pass);
        check_val({name, ".err_cnt"},   32'(err_cnt), e_cnt);
        check_val({name, ".ferr_addr"}, 32'(first_err_addr), e_addr);
        check_val({name, ".ferr_vld"},  32'(first_err_vld), 32'(e_vld));
        check_val({name, ".pass"},      32'(pass), 32'(e_pass));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        load_mem(0);
        run_check("match", 0, 0);
        check_results("match", 0, 0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_results("match_hold", 0, 0, 1'b0, 1'b1);

        load_mem(1);
        run_check("single", 0, 0);
        check_results("single", 1, 12'h7FF, 1'b1, 1'b0);

        load_mem(2);
        run_check("boundary", 0, 0);
        check_results("boundary", 2, 0, 1'b1, 1'b0);

        load_mem(3);
        run_check("allbad", 0, 0);
        check_results("allbad", 32'h1000, 0, 1'b1, 1'b0);

        load_mem(0);
        run_check("busy_start", 100, 0);
        check_results("busy_start", 0, 0, 1'b0, 1'b1);

        load_mem(1);
        run_check("abort", 0, 200);
        run_check("rerun", 0, 0);
        check_results("rerun", 1, 12'h7FF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
